reg_transfer_sequencer: RTL
===========================

// Module: reg_transfer_sequencer
// PURPOSE
//   Control-only sequencer that shares the 4-register transfer bus (A=0, B=1,
//   C=2, const-zero=3) between NREQ requesters, e.g. debounced Load_Gen pulses.
//   Grants requesters round-robin and expands each command (MOVE/CLEAR/SWAP)
//   into bus-select and one-hot register-load strobes. It drives the bus mux
//   select and the Register4b Load pins. It carries no data.
// PARAMETERS
//   NREQ     3   number of requesters (1..4)
//   TEMP_IDX 2   register index used as scratch by SWAP (C)
// PORTS
//   clk      in   1        system clock, rising edge
//   rst_n    in   1        asynchronous, active-low reset
//   req      in   NREQ     level request per requester; held until its ack
//   cmd      in   6*NREQ   per requester i, cmd[6i+5:6i] = {op[1:0], src[1:0], dst[1:0]}
//   bus_sel  out  2        bus mux select (0=A, 1=B, 2=C, 3=zero)
//   load     out  3        one-hot load strobe {C,B,A}, 1 cycle per step
//   ack      out  NREQ     one-hot, 1-cycle completion pulse to the granted requester
//   err      out  1        valid with ack: command rejected, no loads issued
//   busy     out  1        high whenever state != IDLE
// BEHAVIOUR
// - All outputs are registered. Reset: bus_sel=0, load=0, ack=0, err=0, busy=0,
//   state=IDLE, rr pointer=NREQ-1, so requester 0 wins first.
// - Ops:
//   - 00 NOP: err=1.
//   - 01 MOVE src->dst.
//   - 10 SWAP src<->dst, run as 3 steps: src->T, dst->src, T->dst, where T=TEMP_IDX.
//   - 11 CLEAR: 0->dst. src is ignored and the bus is forced to sel=3.
// - Illegal (ack with err=1, no loads):
//   - dst==3 for any op.
//   - SWAP with src==dst, or src/dst equal to 3 or TEMP_IDX.
//   - MOVE with src==dst is legal: it reloads the register with its own value.
// - FSM states: IDLE, DRIVE, LOAD, ACK.
//   - IDLE: if any req is high, grant the first requester searching from
//     ptr+1 mod NREQ, latch its cmd, set ptr=grant, and go to DRIVE.
//     An illegal cmd goes straight to ACK.
//   - DRIVE: bus_sel=step src, load=0.
//   - LOAD: bus_sel held, load=onehot(step dst). Go to DRIVE for the next
//     step, or to ACK after the last step.
//   - ACK: ack[grant]=1 and err set as decided. Next state is IDLE.
// - Step counter is 2 bits. bus_sel stays stable across each DRIVE/LOAD pair,
//   so the register captures a settled bus on the LOAD edge.
// - Latency, counted from the IDLE cycle that samples req to the ack cycle:
//   - MOVE/CLEAR: 3 cycles (DRIVE, LOAD, ACK).
//   - SWAP: 7 cycles.
//   - Illegal: 1 cycle.
//   Each transfer ends with a mandatory IDLE cycle.
// - Handshake: the requester keeps req and cmd stable until it sees ack, and
//   drops req on the next edge. cmd is latched at grant; later changes are
//   ignored. Dropping req mid-transfer does not abort the transfer.
// - Simultaneous requests: only one is granted per IDLE cycle; the others wait.
//   With every req held high the grant order rotates 0,1,2,0,...
//   A requester requesting while busy is serviced after the current ack.
// - Reset mid-transfer: all outputs clear at once and the FSM enters IDLE.
//   A partial SWAP is not restored. The register contents are the
//   requester's concern.
// - Exactly zero or one load bit is high in any cycle. ack and load are never
//   high in the same cycle.
// TESTING
// - Reset: rst_n=0, then 1 -> all outputs 0, busy=0. After a req[0] MOVE
//   B->A: DRIVE bus_sel=1; LOAD load=001; ack=001, err=0; busy high 3 cycles.
// - SWAP A<->B with A=3, B=9 (loads modelled): load sequence 100, 001, 010
//   with bus_sel 0, 1, 2 -> A=9, B=3, C=3; ack on the 7th cycle.
// - CLEAR dst=C with src=1 -> bus_sel=3, load=100, ack, C=0.
// - Illegal: MOVE dst=3, SWAP src=dst=0, SWAP with src=2, NOP
//   -> ack with err=1 after 1 cycle; load stays 000 throughout.
// - Arbitration: req=111 held, each requester re-asserting after its ack
//   -> grant order 0,1,2,0. A req[1] that rises mid-transfer of req[0]
//   is served next.
// - rst_n pulsed low during the second SWAP step -> outputs 0 within the
//   cycle and busy=0. A new MOVE afterwards completes normally.

Source files
------------

// File: rtl/reg_transfer_sequencer.sv
// Round-robin sequencer that arbitrates the shared 4-register transfer bus and
// expands MOVE/CLEAR/SWAP commands into bus-select and one-hot load strobes.
module reg_transfer_sequencer #(
    parameter int unsigned NREQ     = 3,
    parameter int unsigned TEMP_IDX = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [6*NREQ-1:0] cmd,
    output logic [1:0]        bus_sel,
    output logic [2:0]        load,
    output logic [NREQ-1:0]   ack,
    output logic              err,
    output logic              busy
);

    localparam int unsigned MAXREQ   = 4;
    localparam int unsigned CMD_W    = 6;
    localparam logic [1:0]  OP_NOP   = 2'b00;
    localparam logic [1:0]  OP_MOVE  = 2'b01;
    localparam logic [1:0]  OP_SWAP  = 2'b10;
    localparam logic [1:0]  OP_CLEAR = 2'b11;
    localparam logic [1:0]  ZERO_SEL = 2'd3;
    localparam logic [1:0]  TMP_SEL  = 2'(TEMP_IDX);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD, ACK} state_t;

    state_t     state, state_d;
    logic [1:0] step, step_d;
    logic [1:0] op_q, op_d;
    logic [1:0] src_q, src_d;
    logic [1:0] dst_q, dst_d;
    logic [1:0] grant, grant_d;
    logic [1:0] ptr, ptr_d;
    logic [1:0] bus_sel_d;
    logic [2:0] load_d;
    logic [NREQ-1:0] ack_d;
    logic       err_d;
    logic       busy_d;

    logic [MAXREQ-1:0]       req_pad;
    logic [MAXREQ*CMD_W-1:0] cmd_pad;
    logic [CMD_W-1:0]        cmd_arr [MAXREQ];
    logic [CMD_W-1:0]        pick_cmd;
    logic [1:0]              pick;
    logic [1:0]              cand;
    logic                    found;

    // Bus source for a given step of the latched command.
    function automatic logic [1:0] step_src(input logic [1:0] op, input logic [1:0] src,
                                            input logic [1:0] dst, input logic [1:0] stp);
        logic [1:0] r;
        r = src;
        if (op == OP_CLEAR) begin
            r = ZERO_SEL;
        end else if (op == OP_SWAP) begin
            case (stp)
                2'd0:    r = src;
                2'd1:    r = dst;
                default: r = TMP_SEL;
            endcase
        end
        return r;
    endfunction

    // Destination register for a given step of the latched command.
    function automatic logic [1:0] step_dst(input logic [1:0] op, input logic [1:0] src,
                                            input logic [1:0] dst, input logic [1:0] stp);
        logic [1:0] r;
        r = dst;
        if (op == OP_SWAP) begin
            case (stp)
                2'd0:    r = TMP_SEL;
                2'd1:    r = src;
                default: r = dst;
            endcase
        end
        return r;
    endfunction

    // Commands that are acked with err and never touch a register.
    function automatic logic is_illegal(input logic [1:0] op, input logic [1:0] src,
                                        input logic [1:0] dst);
        logic r;
        r = (op == OP_NOP) || (dst == ZERO_SEL);
        if (op == OP_SWAP) begin
            r = r || (src == dst) || (src == ZERO_SEL) || (src == TMP_SEL) || (dst == TMP_SEL);
        end
        return r;
    endfunction

    // Round-robin pick: first active requester after the last grant.
    always_comb begin
        req_pad = MAXREQ'(req);
        cmd_pad = (MAXREQ*CMD_W)'(cmd);
        for (int i = 0; i < int'(MAXREQ); i++) begin
            cmd_arr[i] = cmd_pad[CMD_W*i +: CMD_W];
        end
        found = 1'b0;
        pick  = ptr;
        cand  = 2'd0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = 2'((32'(ptr) + k) % NREQ);
            if (!found && req_pad[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
        pick_cmd = cmd_arr[pick];
    end

    // Next state and next registered outputs.
    always_comb begin
        state_d   = state;
        step_d    = step;
        op_d      = op_q;
        src_d     = src_q;
        dst_d     = dst_q;
        grant_d   = grant;
        ptr_d     = ptr;
        bus_sel_d = bus_sel;
        load_d    = 3'b000;
        ack_d     = '0;
        err_d     = 1'b0;

        case (state)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    ptr_d   = pick;
                    op_d    = pick_cmd[5:4];
                    src_d   = pick_cmd[3:2];
                    dst_d   = pick_cmd[1:0];
                    step_d  = 2'd0;
                    if (is_illegal(pick_cmd[5:4], pick_cmd[3:2], pick_cmd[1:0])) begin
                        state_d = ACK;
                        ack_d   = NREQ'(1) << pick;
                        err_d   = 1'b1;
                    end else begin
                        state_d   = DRIVE;
                        bus_sel_d = step_src(pick_cmd[5:4], pick_cmd[3:2], pick_cmd[1:0], 2'd0);
                    end
                end
            end
            DRIVE: begin
                state_d = LOAD;
                load_d  = 3'b001 << step_dst(op_q, src_q, dst_q, step);
            end
            LOAD: begin
                if (op_q != OP_SWAP || step == 2'd2) begin
                    state_d = ACK;
                    ack_d   = NREQ'(1) << grant;
                end else begin
                    state_d   = DRIVE;
                    step_d    = step + 2'd1;
                    bus_sel_d = step_src(op_q, src_q, dst_q, step + 2'd1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State, latched command and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            step    <= 2'd0;
            op_q    <= OP_NOP;
            src_q   <= 2'd0;
            dst_q   <= 2'd0;
            grant   <= 2'd0;
            ptr     <= 2'(NREQ - 1);
            bus_sel <= 2'd0;
            load    <= 3'b000;
            ack     <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            step    <= step_d;
            op_q    <= op_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            grant   <= grant_d;
            ptr     <= ptr_d;
            bus_sel <= bus_sel_d;
            load    <= load_d;
            ack     <= ack_d;
            err     <= err_d;
            busy    <= busy_d;
        end
    end

endmodule
